// File: rtl/dependency_detector.sv
// dependency_detector: ID-stage data-dependency and load-use hazard detector.
// Tracks the destinations of the two instructions ahead of ID (EX and MEM
// shadow entries) and emits the registered forwarding vector for EXE plus a
// combinational load-use stall.
module dependency_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wreg,
  input  logic [4:0] id_rn,
  input  logic       id_m2reg,
  input  logic       flush,
  output logic       stall,
  output logic [3:0] depen,
  output logic       ex_wreg,
  output logic [4:0] ex_rn,
  output logic       ex_m2reg,
  output logic       mem_wreg,
  output logic [4:0] mem_rn
);

  // A source matches a producer when it is really read, is not r0, and the
  // producer writes that same register.
  function automatic logic src_match(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic       prod_wreg,
                                     input logic [4:0] prod_rn);
    src_match = use_src & prod_wreg & (prod_rn == src) & (src != 5'd0);
  endfunction

  logic       ex_wreg_r;
  logic [4:0] ex_rn_r;
  logic       ex_m2reg_r;
  logic       mem_wreg_r;
  logic [4:0] mem_rn_r;
  logic [3:0] depen_r;

  logic       a1_s;
  logic       b1_s;
  logic       a2_s;
  logic       b2_s;
  logic       stall_s;
  logic       bubble_s;
  logic       next_wreg_s;

  // Hazard matching against the current shadow entries; the nearer producer
  // masks the farther one so each operand selects at most one forward path.
  always_comb begin
    a1_s        = src_match(id_use_rs, id_rs, ex_wreg_r, ex_rn_r);
    b1_s        = src_match(id_use_rt, id_rt, ex_wreg_r, ex_rn_r);
    a2_s        = src_match(id_use_rs, id_rs, mem_wreg_r, mem_rn_r) & ~a1_s;
    b2_s        = src_match(id_use_rt, id_rt, mem_wreg_r, mem_rn_r) & ~b1_s;
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    next_wreg_s = id_wreg & (id_rn != 5'd0);
    // A load in EX cannot forward in time; flush overrides the hold request.
    if (id_valid && !flush && ex_m2reg_r && (a1_s || b1_s)) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    if (flush || stall_s || !id_valid) begin
      bubble_s = 1'b1;
    end else begin
      bubble_s = 1'b0;
    end
  end

  // Two-entry destination shift plus the registered forwarding vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_wreg_r  <= 1'b0;
      ex_rn_r    <= 5'd0;
      ex_m2reg_r <= 1'b0;
      mem_wreg_r <= 1'b0;
      mem_rn_r   <= 5'd0;
      depen_r    <= 4'b0000;
    end else begin
      mem_wreg_r <= ex_wreg_r;
      mem_rn_r   <= ex_rn_r;
      if (bubble_s) begin
        ex_wreg_r  <= 1'b0;
        ex_rn_r    <= 5'd0;
        ex_m2reg_r <= 1'b0;
        depen_r    <= 4'b0000;
      end else begin
        ex_wreg_r  <= next_wreg_s;
        ex_rn_r    <= id_rn;
        ex_m2reg_r <= id_m2reg;
        depen_r    <= {a1_s, b1_s, a2_s, b2_s};
      end
    end
  end

  assign stall    = stall_s;
  assign depen    = depen_r;
  assign ex_wreg  = ex_wreg_r;
  assign ex_rn    = ex_rn_r;
  assign ex_m2reg = ex_m2reg_r;
  assign mem_wreg = mem_wreg_r;
  assign mem_rn   = mem_rn_r;

endmodule
